// File: rtl/imem_boot_loader.sv
// Boot loader: streams program bytes into instruction memory (MSB first), then
// releases the CPU from reset and watches its PC for completion or timeout.
module imem_boot_loader #(
  parameter int unsigned ROM_DEPTH = 256,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rstn,
  input  logic [31:0] pc_addr,
  input  logic [31:0] done_addr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Largest word count the 8-bit address can reach without exceeding the ROM.
  localparam int unsigned MAX_WORDS = (ROM_DEPTH > 255) ? 255 : ROM_DEPTH;
  localparam logic [15:0] RUN_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, HALT} state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  word_cnt;
  logic [7:0]  word_addr;
  logic [1:0]  byte_idx;
  logic [31:0] asm_word;
  logic [15:0] run_cnt;
  logic        xfer;
  logic        pc_match;
  logic        last_word;

  assign pc_match  = (pc_addr == done_addr);
  assign last_word = (8'(word_addr + 8'd1) == word_cnt);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; match takes priority over timeout in RUN
  always_comb begin
    next_state = state;
    xfer       = 1'b0;
    case (state)
      IDLE:  if (start) next_state = (word_count != 8'd0) ? LOAD : RUN;
      LOAD: begin
        if (byte_valid) begin
          xfer = 1'b1;
          if (byte_idx == 2'd3) next_state = WRITE;
        end
      end
      WRITE: next_state = last_word ? RUN : LOAD;
      RUN: begin
        if (pc_match)                 next_state = HALT;
        else if (run_cnt == RUN_LAST) next_state = HALT;
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs, all decoded from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 8'd0;
      wr_data    <= 32'd0;
      cpu_rstn   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= 8'd0;
      word_addr  <= 8'd0;
      byte_idx   <= 2'd0;
      asm_word   <= 32'd0;
      run_cnt    <= 16'd0;
    end else begin
      byte_ready <= (next_state == LOAD);
      wr_en      <= (next_state == WRITE);
      cpu_rstn   <= (next_state == RUN);
      busy       <= (next_state == LOAD) || (next_state == WRITE) || (next_state == RUN);
      case (state)
        IDLE: begin
          if (start) begin
            word_cnt  <= (32'(word_count) > MAX_WORDS) ? 8'(MAX_WORDS) : word_count;
            word_addr <= 8'd0;
            byte_idx  <= 2'd0;
            asm_word  <= 32'd0;
            run_cnt   <= 16'd0;
          end
        end
        LOAD: begin
          if (xfer) begin
            asm_word <= {asm_word[23:0], byte_data};
            byte_idx <= 2'(byte_idx + 2'd1);
            if (byte_idx == 2'd3) begin
              wr_data <= {asm_word[23:0], byte_data};
              wr_addr <= word_addr;
            end
          end
        end
        WRITE: word_addr <= 8'(word_addr + 8'd1);
        RUN: begin
          run_cnt <= 16'(run_cnt + 16'd1);
          if (next_state == HALT) begin
            done <= pc_match;
            err  <= ~pc_match;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: expected writes are queued at stimulus
// time and popped by a monitor on every wr_en; run outcomes come from a cycle model.
module tb_imem_boot_loader;

  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rstn;
  logic [31:0] pc_addr;
  logic [31:0] done_addr;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] stream[$];
  wr_t        exp_q[$];

  imem_boot_loader #(.ROM_DEPTH(256), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_rstn(cpu_rstn),
    .pc_addr(pc_addr), .done_addr(done_addr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued word
  always @(negedge clk) begin
    if (rst === 1'b0 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.a));
        check("wr_data", 64'(wr_data), 64'(e.d));
        check("ready_in_write", 64'(byte_ready), 64'd0);
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_wr_en"},      64'(wr_en),      64'd0);
    check({tag, "_wr_addr"},    64'(wr_addr),    64'd0);
    check({tag, "_wr_data"},    64'(wr_data),    64'd0);
    check({tag, "_cpu_rstn"},   64'(cpu_rstn),   64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_done"},       64'(done),       64'd0);
    check({tag, "_err"},        64'(err),        64'd0);
  endtask

  // Asynchronous reset pulse away from the clock edge
  task automatic apply_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset(tag);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fill_random(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
  endtask

  // Reference: words are big-endian groupings of the byte stream at consecutive addresses
  task automatic push_words(input int nwords);
    for (int i = 0; i < nwords; i++) begin
      wr_t e;
      e.a = 8'(i);
      e.d = (32'(stream[4*i]) << 24) | (32'(stream[4*i+1]) << 16) |
            (32'(stream[4*i+2]) << 8) | 32'(stream[4*i+3]);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_load(input int wc);
    start = 1'b1;
    word_count = 8'(wc);
    @(posedge clk); #1;
    start = 1'b0;
    word_count = 8'($urandom);
  endtask

  task automatic feed(input int nbytes, input bit rnd);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < nbytes && guard < 2000) begin
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = byte_valid ? stream[idx] : 8'($urandom);
      @(negedge clk);
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    byte_valid = 1'b0;
    check("feed_bytes_accepted", 64'(idx), 64'(nbytes));
  endtask

  // Run phase: pc = 4*n in RUN cycle n; match cycle m (or -1 for never)
  task automatic run_phase(input int m);
    int wait_cyc = 0;
    int edges = 0;
    int exp_edges;
    bit exp_done;
    logic done_s, err_s;
    done_addr = (m >= 0) ? 32'(4 * m) : 32'hDEAD_0001;
    if (m >= 0 && m < int'(TO)) begin exp_done = 1'b1; exp_edges = m + 1; end
    else begin exp_done = 1'b0; exp_edges = int'(TO); end
    while (cpu_rstn !== 1'b1 && wait_cyc < 200) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("run_entry_rstn", 64'(cpu_rstn), 64'd1);
    check("run_busy", 64'(busy), 64'd1);
    check("run_byte_ready", 64'(byte_ready), 64'd0);
    pc_addr = 32'd0;
    while (!(done === 1'b1 || err === 1'b1) && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      pc_addr = 32'(4 * edges);
    end
    check("run_cycles", 64'(edges), 64'(exp_edges));
    check("halt_done", 64'(done), 64'(exp_done));
    check("halt_err", 64'(err), 64'(!exp_done));
    check("halt_rstn", 64'(cpu_rstn), 64'd0);
    check("halt_busy", 64'(busy), 64'd0);
    done_s = done;
    err_s = err;
    start = 1'b1;
    word_count = 8'd1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    check("halt_done_stable", 64'(done), 64'(done_s));
    check("halt_err_stable", 64'(err), 64'(err_s));
    check("halt_ignores_start", 64'(busy), 64'd0);
    pc_addr = 32'd2;
  endtask

  initial begin
    logic [7:0] dir [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
    rst = 1'b1; start = 1'b0; word_count = 8'd0; byte_valid = 1'b0; byte_data = 8'd0;
    pc_addr = 32'd2; done_addr = 32'hDEAD_0001;
    #3 check_reset("por");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed two-word load, done at PC 0x1C
    stream.delete();
    for (int i = 0; i < 8; i++) stream.push_back(dir[i]);
    push_words(2);
    start_load(2);
    feed(8, 1'b0);
    run_phase(7);
    check("directed_writes_drained", 64'(exp_q.size()), 64'd0);

    // Same words under random byte_valid, then timeout
    apply_reset("rst1");
    push_words(2);
    start_load(2);
    feed(8, 1'b1);
    run_phase(-1);
    check("random_valid_writes_drained", 64'(exp_q.size()), 64'd0);

    // Zero-word load goes straight to RUN; match on last cycle beats timeout
    apply_reset("rst2");
    start_load(0);
    check("wc0_rstn_next_cycle", 64'(cpu_rstn), 64'd1);
    run_phase(int'(TO) - 1);

    // Reset after 6 bytes of a 2-word load, with a long stall first
    apply_reset("rst3");
    fill_random(8);
    push_words(1);
    start_load(2);
    repeat (40) @(posedge clk);
    #1;
    check("stall_busy", 64'(busy), 64'd1);
    check("stall_ready", 64'(byte_ready), 64'd1);
    check("stall_no_err", 64'(err), 64'd0);
    feed(6, 1'b0);
    apply_reset("mid_load");
    check("mid_load_word0_only", 64'(exp_q.size()), 64'd0);
    repeat (5) @(posedge clk);
    #1 check("idle_after_reset", 64'(busy), 64'd0);
    fill_random(8);
    push_words(2);
    start_load(2);
    feed(8, 1'b1);
    run_phase(int'($urandom_range(0, 20)));
    check("reload_writes_drained", 64'(exp_q.size()), 64'd0);

    // Randomized loads and run outcomes
    for (int it = 0; it < 5; it++) begin
      int wc;
      int m;
      apply_reset("rst_loop");
      wc = int'($urandom_range(0, 5));
      m = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
      fill_random(4 * wc);
      push_words(wc);
      start_load(wc);
      feed(4 * wc, 1'b1);
      run_phase(m);
      check("loop_writes_drained", 64'(exp_q.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
